// File: rtl/craps_controller.sv
// rtl/craps_controller.sv - craps game controller driving the dice roller.
// Optional win/loss statistics counters are enabled by defining CRAPS_STATS_EN.
module craps_controller #(
  parameter int ROLL_LATENCY = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             roll_btn,
  input  logic [2:0]       dice1_in,
  input  logic [2:0]       dice2_in,
  output logic             roll,
  output logic [3:0]       sum,
  output logic [3:0]       point,
  output logic             win,
  output logic             lose,
  output logic             result_valid,
  output logic [2:0]       game_state,
  output logic [CNT_W-1:0] roll_count,
  output logic [CNT_W-1:0] wins,
  output logic [CNT_W-1:0] losses
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    EVAL  = 3'd3,
    POINT = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_t;

  localparam logic [3:0]       LAT     = 4'(ROLL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic       roll_btn_q;
  logic [3:0] wait_cnt;
  logic [2:0] d1;
  logic [2:0] d2;
  logic       btn_edge;
  logic       dice_bad;
  logic [3:0] eval_sum;

  assign btn_edge   = roll_btn & ~roll_btn_q;
  assign dice_bad   = (d1 == 3'd0) || (d1 == 3'd7) || (d2 == 3'd0) || (d2 == 3'd7);
  assign eval_sum   = {1'b0, d1} + {1'b0, d2};
  assign game_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      roll_btn_q   <= 1'b0;
      wait_cnt     <= 4'd0;
      d1           <= 3'd0;
      d2           <= 3'd0;
      roll         <= 1'b0;
      sum          <= 4'd0;
      point        <= 4'd0;
      win          <= 1'b0;
      lose         <= 1'b0;
      result_valid <= 1'b0;
      roll_count   <= '0;
`ifdef CRAPS_STATS_EN
      wins         <= '0;
      losses       <= '0;
`endif
    end else begin
      roll_btn_q   <= roll_btn;
      roll         <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE, POINT: begin
          if (btn_edge) begin
            state <= REQ;
            roll  <= 1'b1;
          end
        end
        WIN, LOSE: begin
          // A press after a finished game starts a fresh one.
          if (btn_edge) begin
            state      <= REQ;
            roll       <= 1'b1;
            point      <= 4'd0;
            win        <= 1'b0;
            lose       <= 1'b0;
            roll_count <= '0;
          end
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= LAT;
        end
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            d1    <= dice1_in;
            d2    <= dice2_in;
            state <= EVAL;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        EVAL: begin
          if (dice_bad) begin
            // Out-of-range die: silently re-roll.
            state <= REQ;
            roll  <= 1'b1;
          end else begin
            sum          <= eval_sum;
            result_valid <= 1'b1;
            if (roll_count != '1) roll_count <= roll_count + CNT_ONE;
            if ((point == 4'd0 && (eval_sum == 4'd7 || eval_sum == 4'd11)) ||
                (point != 4'd0 && eval_sum == point)) begin
              state <= WIN;
              win   <= 1'b1;
`ifdef CRAPS_STATS_EN
              if (wins != '1) wins <= wins + CNT_ONE;
`endif
            end else if ((point == 4'd0 && (eval_sum == 4'd2 || eval_sum == 4'd3 ||
                                            eval_sum == 4'd12)) ||
                         (point != 4'd0 && eval_sum == 4'd7)) begin
              state <= LOSE;
              lose  <= 1'b1;
`ifdef CRAPS_STATS_EN
              if (losses != '1) losses <= losses + CNT_ONE;
`endif
            end else begin
              if (point == 4'd0) point <= eval_sum;
              state <= POINT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CRAPS_STATS_EN
  assign wins   = '0;
  assign losses = '0;
`endif

endmodule

// File: tb/tb_craps_controller.sv
// tb/tb_craps_controller.sv - self-checking bench for craps_controller.
// Honours CRAPS_STATS_EN the same way as the design.
module tb_craps_controller;
  localparam int LAT   = 1;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             roll_btn = 1'b0;
  logic [2:0]       dice1_in = 3'd1;
  logic [2:0]       dice2_in = 3'd1;
  logic             roll;
  logic [3:0]       sum;
  logic [3:0]       point;
  logic             win;
  logic             lose;
  logic             result_valid;
  logic [2:0]       game_state;
  logic [CNT_W-1:0] roll_count;
  logic [CNT_W-1:0] wins;
  logic [CNT_W-1:0] losses;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model kept as plain integers following the table rules.
  int m_sum = 0, m_point = 0, m_count = 0, m_wins = 0, m_losses = 0;
  bit m_win = 0, m_lose = 0;

  craps_controller #(.ROLL_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .roll_btn(roll_btn), .dice1_in(dice1_in), .dice2_in(dice2_in),
    .roll(roll), .sum(sum), .point(point), .win(win), .lose(lose),
    .result_valid(result_valid), .game_state(game_state), .roll_count(roll_count),
    .wins(wins), .losses(losses)
  );

  always #5 clk = ~clk;

  function automatic int m_state();
    if (m_win) return 5;
    if (m_lose) return 6;
    if (m_point != 0) return 4;
    return 0;
  endfunction

  function automatic logic [36:0] exp_vec();
    logic [7:0] ew, el;
`ifdef CRAPS_STATS_EN
    ew = 8'(m_wins);
    el = 8'(m_losses);
`else
    ew = 8'd0;
    el = 8'd0;
`endif
    return {4'(m_sum), 4'(m_point), m_win, m_lose, 3'(m_state()), 8'(m_count), ew, el};
  endfunction

  function automatic logic [36:0] obs_vec();
    return {sum, point, win, lose, game_state, roll_count, wins, losses};
  endfunction

  task automatic model_reset();
    m_sum = 0; m_point = 0; m_count = 0; m_wins = 0; m_losses = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic model_press();
    if (m_win || m_lose) begin
      m_point = 0; m_win = 0; m_lose = 0; m_count = 0;
    end
  endtask

  task automatic model_eval(input int a, input int b);
    int s;
    s = a + b;
    m_sum = s;
    m_count = (m_count < 255) ? m_count + 1 : 255;
    if (m_point == 0) begin
      if (s == 7 || s == 11) begin m_win = 1; m_wins++; end
      else if (s == 2 || s == 3 || s == 12) begin m_lose = 1; m_losses++; end
      else m_point = s;
    end else if (s == m_point) begin
      m_win = 1; m_wins++;
    end else if (s == 7) begin
      m_lose = 1; m_losses++;
    end
  endtask

  // Press the button with fixed dice; report result cycle, roll pulse count, first roll cycle.
  task automatic press_and_wait(input int a, input int b, output int lat, output int pulses,
                                output int first);
    dice1_in = 3'(a);
    dice2_in = 3'(b);
    @(negedge clk);
    roll_btn = 1'b1;
    lat = -1; pulses = 0; first = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      roll_btn = 1'b0;
      if (roll) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (result_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== 37'd0 || roll !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h roll=%b rv=%b, want 0", obs_vec(), roll, result_valid);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_come_out_win();
    int lat, pulses, first;
    model_press(); model_eval(3, 4);
    press_and_wait(3, 4, lat, pulses, first);
    n_checks++;
    if (lat !== 3 + LAT || pulses !== 1 || first !== 1) begin
      n_fail++;
      $display("FAIL come_out_timing: lat=%0d pulses=%0d first=%0d, want %0d 1 1", lat, pulses, first, 3 + LAT);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL come_out_win: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_point_made();
    int da[3] = '{2, 1, 3};
    int db[3] = '{2, 5, 1};
    int lat, pulses, first;
    for (int i = 0; i < 3; i++) begin
      model_press(); model_eval(da[i], db[i]);
      press_and_wait(da[i], db[i], lat, pulses, first);
      n_checks++;
      if (lat !== 3 + LAT || pulses !== 1) begin
        n_fail++;
        $display("FAIL point_made_timing[%0d]: lat=%0d pulses=%0d", i, lat, pulses);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL point_made[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_point_lost_craps();
    int da[3] = '{4, 6, 1};
    int db[3] = '{5, 1, 1};
    int lat, pulses, first;
    for (int i = 0; i < 3; i++) begin
      model_press(); model_eval(da[i], db[i]);
      press_and_wait(da[i], db[i], lat, pulses, first);
      n_checks++;
      if (lat !== 3 + LAT || pulses !== 1) begin
        n_fail++;
        $display("FAIL lost_timing[%0d]: lat=%0d pulses=%0d", i, lat, pulses);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL point_lost_craps[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_invalid_dice();
    int lat = -1, pulses = 0;
    model_press(); model_eval(5, 6);
    dice1_in = 3'd0;
    dice2_in = 3'd6;
    @(negedge clk);
    roll_btn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      roll_btn = 1'b0;
      if (roll) pulses++;
      if (c == 2 + LAT) dice1_in = 3'd5;
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat !== 5 + 2 * LAT || pulses !== 2) begin
      n_fail++;
      $display("FAIL invalid_retry: lat=%0d pulses=%0d, want %0d 2", lat, pulses, 5 + 2 * LAT);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL invalid_result: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_busy();
    int tcyc[2] = '{2, 2 + LAT};
    int da[2]   = '{6, 5};
    int db[2]   = '{6, 6};
    for (int i = 0; i < 2; i++) begin
      int lat = -1, pulses = 0;
      model_press(); model_eval(da[i], db[i]);
      dice1_in = 3'(da[i]);
      dice2_in = 3'(db[i]);
      @(negedge clk);
      roll_btn = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        roll_btn = (c == tcyc[i]);
        if (roll) pulses++;
        if (result_valid) begin
          lat = c;
          break;
        end
      end
      roll_btn = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (roll) pulses++;
      end
      n_checks++;
      if (lat !== 3 + LAT || pulses !== 1) begin
        n_fail++;
        $display("FAIL busy_ignore[%0d]: lat=%0d pulses=%0d, want %0d 1", i, lat, pulses, 3 + LAT);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL busy_result[%0d]: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int pulses = 0, rvs = 0;
    dice1_in = 3'd3;
    dice2_in = 3'd4;
    @(negedge clk);
    roll_btn = 1'b1;
    @(negedge clk);
    roll_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 37'd0 || roll !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %h roll=%b rv=%b, want 0", obs_vec(), roll, result_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (roll) pulses++;
      if (result_valid) rvs++;
    end
    n_checks++;
    if (pulses !== 0 || rvs !== 0 || obs_vec() !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_no_roll: pulses=%0d rv=%0d state=%h, want 0 0 0", pulses, rvs, obs_vec());
    end
  endtask

  task automatic test_random();
    int a, b, lat, pulses, first;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(1, 6));
      b = int'($urandom_range(1, 6));
      model_press(); model_eval(a, b);
      press_and_wait(a, b, lat, pulses, first);
      n_checks++;
      if (lat !== 3 + LAT || pulses !== 1 || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d] dice %0d,%0d: lat=%0d pulses=%0d got %h want %h",
                 i, a, b, lat, pulses, obs_vec(), exp_vec());
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_come_out_win();
    test_point_made();
    test_point_lost_craps();
    test_invalid_dice();
    test_busy();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
